// File: rtl/trace_pkg.sv
// Shared constants for the instruction-trace capture block: FSM state codes,
// capture-mode codes and the bit layout of the default probe word.
package trace_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_CAPTURE = 2'd1;
  localparam logic [1:0] ST_POST    = 2'd2;
  localparam logic [1:0] ST_FROZEN  = 2'd3;

  localparam logic [1:0] MODE_RING = 2'd0;
  localparam logic [1:0] MODE_STOP = 2'd1;
  localparam logic [1:0] MODE_TRIG = 2'd2;

  // Default 40-bit probe word is {hl[15:0], a[7:0], f[7:0], mem[7:0]}.
  localparam int PROBE_MEM_LSB = 0;
  localparam int PROBE_MEM_W   = 8;
  localparam int PROBE_F_LSB   = 8;
  localparam int PROBE_F_W     = 8;
  localparam int PROBE_A_LSB   = 16;
  localparam int PROBE_A_W     = 8;
  localparam int PROBE_HL_LSB  = 24;
  localparam int PROBE_HL_W    = 16;

endpackage

// File: rtl/trace_ram.sv
// Trace record store: one synchronous write port, one asynchronous read port
// so the oldest record is presented on the readout stream with no added latency.
module trace_ram #(
  parameter int DEPTH  = 64,
  parameter int WIDTH  = 56,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/cpu_trace_buffer.sv
// Instruction-trace capture buffer: samples {pc, probe} once per M1 into a
// circular store under ring/stop/PC-trigger modes, then drains it oldest-first.
module cpu_trace_buffer
  import trace_pkg::*;
#(
  parameter int DEPTH   = 64,
  parameter int PROBE_W = 40,
  parameter int PC_W    = 16,
  parameter int ADDR_W  = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    sample_en,
  input  logic [PC_W-1:0]         sample_pc,
  input  logic [PROBE_W-1:0]      sample_probe,
  input  logic [1:0]              mode,
  input  logic                    arm,
  input  logic                    halt,
  input  logic [PC_W-1:0]         trig_pc,
  input  logic [ADDR_W-1:0]       post_trig,
  output logic                    rd_valid,
  input  logic                    rd_ready,
  output logic [PC_W+PROBE_W-1:0] rd_data,
  output logic [ADDR_W:0]         count,
  output logic [1:0]              state,
  output logic                    overflow,
  output logic                    triggered
);

  localparam int REC_W = PC_W + PROBE_W;
  localparam logic [ADDR_W:0]   CNT_FULL = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              overflow_q, overflow_d;
  logic              triggered_q, triggered_d;
  logic [ADDR_W-1:0] post_cnt_q, post_cnt_d;
  logic [1:0]        mode_q, mode_d;
  logic [PC_W-1:0]   trig_pc_q, trig_pc_d;
  logic [ADDR_W-1:0] post_trig_q, post_trig_d;

  logic wr_en;
  logic rd_fire;
  logic trig_hit;

  assign wr_en    = sample_en && (state_q == ST_CAPTURE || state_q == ST_POST);
  assign rd_valid = (state_q == ST_FROZEN) && (count_q != '0);
  assign rd_fire  = rd_valid && rd_ready;
  assign trig_hit = wr_en && (state_q == ST_CAPTURE) && (mode_q == MODE_TRIG) &&
                    (sample_pc == trig_pc_q);

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    triggered_d = triggered_q;
    post_cnt_d  = post_cnt_q;
    mode_d      = mode_q;
    trig_pc_d   = trig_pc_q;
    post_trig_d = post_trig_q;

    case (state_q)
      ST_IDLE, ST_FROZEN: begin
        if (arm) begin
          state_d     = ST_CAPTURE;
          wr_ptr_d    = '0;
          rd_ptr_d    = '0;
          count_d     = '0;
          overflow_d  = 1'b0;
          triggered_d = 1'b0;
          post_cnt_d  = '0;
          mode_d      = mode;
          trig_pc_d   = trig_pc;
          // ADDR_W bits already cap post_trig at DEPTH-1, so the trigger record survives POST.
          post_trig_d = post_trig;
        end else if (rd_fire) begin
          rd_ptr_d = rd_ptr_q + PTR_ONE;
          count_d  = count_q - CNT_ONE;
        end
      end

      default: begin
        if (wr_en) begin
          wr_ptr_d = wr_ptr_q + PTR_ONE;
          if (count_q == CNT_FULL) begin
            rd_ptr_d   = rd_ptr_q + PTR_ONE;
            overflow_d = 1'b1;
          end else begin
            count_d = count_q + CNT_ONE;
          end
          if (trig_hit) begin
            triggered_d = 1'b1;
          end
          if (mode_q == MODE_STOP && count_q == CNT_FULL - CNT_ONE) begin
            state_d = ST_FROZEN;
          end else if (trig_hit) begin
            if (post_trig_q == '0) begin
              state_d = ST_FROZEN;
            end else begin
              state_d    = ST_POST;
              post_cnt_d = post_trig_q;
            end
          end else if (state_q == ST_POST) begin
            post_cnt_d = post_cnt_q - PTR_ONE;
            if (post_cnt_q == PTR_ONE) begin
              state_d = ST_FROZEN;
            end
          end
        end
        if (halt) begin
          state_d = ST_FROZEN;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      triggered_q <= 1'b0;
      post_cnt_q  <= '0;
      mode_q      <= MODE_RING;
      trig_pc_q   <= '0;
      post_trig_q <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      triggered_q <= triggered_d;
      post_cnt_q  <= post_cnt_d;
      mode_q      <= mode_d;
      trig_pc_q   <= trig_pc_d;
      post_trig_q <= post_trig_d;
    end
  end

  trace_ram #(
    .DEPTH (DEPTH),
    .WIDTH (REC_W),
    .ADDR_W(ADDR_W)
  ) u_ram (
    .clk  (clk),
    .we   (wr_en),
    .waddr(wr_ptr_q),
    .wdata({sample_pc, sample_probe}),
    .raddr(rd_ptr_q),
    .rdata(rd_data)
  );

  assign count     = count_q;
  assign state     = state_q;
  assign overflow  = overflow_q;
  assign triggered = triggered_q;

endmodule

// File: tb/tb_cpu_trace_buffer.sv
// Bench for cpu_trace_buffer (DEPTH=8): directed capture/readout scenarios then
// random traffic, all checked against a queue-based model of the trace rules.
module tb_cpu_trace_buffer;

  localparam int DEPTH   = 8;
  localparam int PROBE_W = 40;
  localparam int PC_W    = 16;
  localparam int ADDR_W  = 3;
  localparam int REC_W   = PC_W + PROBE_W;

  logic               clk = 1'b0;
  logic               rst;
  logic               sample_en;
  logic [PC_W-1:0]    sample_pc;
  logic [PROBE_W-1:0] sample_probe;
  logic [1:0]         mode;
  logic               arm;
  logic               halt;
  logic [PC_W-1:0]    trig_pc;
  logic [ADDR_W-1:0]  post_trig;
  logic               rd_valid;
  logic               rd_ready;
  logic [REC_W-1:0]   rd_data;
  logic [ADDR_W:0]    count;
  logic [1:0]         state;
  logic               overflow;
  logic               triggered;

  int tests = 0;
  int fails = 0;

  // Reference model: the buffer is a plain queue of records, oldest at index 0.
  logic [REC_W-1:0] mq[$];
  int               m_state;
  bit               m_ovf;
  bit               m_trig;
  int               m_post_left;
  int               m_mode;
  logic [PC_W-1:0]  m_tpc;
  int               m_post_len;

  always #5 clk = ~clk;

  cpu_trace_buffer #(
    .DEPTH  (DEPTH),
    .PROBE_W(PROBE_W),
    .PC_W   (PC_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .sample_en   (sample_en),
    .sample_pc   (sample_pc),
    .sample_probe(sample_probe),
    .mode        (mode),
    .arm         (arm),
    .halt        (halt),
    .trig_pc     (trig_pc),
    .post_trig   (post_trig),
    .rd_valid    (rd_valid),
    .rd_ready    (rd_ready),
    .rd_data     (rd_data),
    .count       (count),
    .state       (state),
    .overflow    (overflow),
    .triggered   (triggered)
  );

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_step(input bit r, input bit a, input bit h, input bit s,
                            input logic [REC_W-1:0] rec, input bit rr);
    bit hit;
    if (r) begin
      mq.delete();
      m_state = 0; m_ovf = 0; m_trig = 0; m_post_left = 0;
      return;
    end
    if (m_state == 0 || m_state == 3) begin
      if (a) begin
        mq.delete();
        m_state = 1; m_ovf = 0; m_trig = 0; m_post_left = 0;
        m_mode = int'(mode); m_tpc = trig_pc; m_post_len = int'(post_trig);
      end else if (m_state == 3 && mq.size() > 0 && rr) begin
        mq.delete(0);
      end
    end else begin
      hit = 0;
      if (s) begin
        mq.push_back(rec);
        if (mq.size() > DEPTH) begin
          mq.delete(0);
          m_ovf = 1;
        end
        hit = (m_state == 1) && (m_mode == 2) && (rec[REC_W-1 -: PC_W] == m_tpc);
        if (hit) m_trig = 1;
        if (m_mode == 1 && mq.size() == DEPTH) m_state = 3;
        else if (hit) begin
          if (m_post_len == 0) m_state = 3;
          else begin
            m_state = 2;
            m_post_left = m_post_len;
          end
        end else if (m_state == 2) begin
          m_post_left--;
          if (m_post_left == 0) m_state = 3;
        end
      end
      if (h) m_state = 3;
    end
  endtask

  task automatic checkOutput();
    bit exp_valid;
    exp_valid = (m_state == 3) && (mq.size() > 0);
    check_val("state", 64'(state), 64'(m_state));
    check_val("count", 64'(count), 64'(mq.size()));
    check_val("rd_valid", 64'(rd_valid), 64'(exp_valid));
    check_val("overflow", 64'(overflow), 64'(m_ovf));
    check_val("triggered", 64'(triggered), 64'(m_trig));
    if (exp_valid) check_val("rd_data", 64'(rd_data), 64'(mq[0]));
  endtask

  task automatic applyStimulus(input bit r, input bit a, input bit h, input bit s,
                               input logic [PC_W-1:0] pc, input bit rr);
    logic [63:0] rnd;
    rnd = {$urandom(), $urandom()};
    rst = r; arm = a; halt = h; sample_en = s; sample_pc = pc;
    sample_probe = rnd[PROBE_W-1:0]; rd_ready = rr;
    model_step(r, a, h, s, {pc, rnd[PROBE_W-1:0]}, rr);
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  task automatic arm_with(input logic [1:0] md, input logic [PC_W-1:0] tp, input logic [ADDR_W-1:0] pt);
    mode = md; trig_pc = tp; post_trig = pt;
    applyStimulus(0, 1, 0, 0, '0, 0);
  endtask

  task automatic sample(input logic [PC_W-1:0] pc);
    applyStimulus(0, 0, 0, 1, pc, 0);
  endtask

  task automatic idle(input bit rr);
    applyStimulus(0, 0, 0, 0, '0, rr);
  endtask

  task automatic drain();
    repeat (DEPTH + 2) idle(1);
    check_val("drained_valid", 64'(rd_valid), 64'(0));
  endtask

  initial begin
    logic [REC_W-1:0] held;
    rst = 1; arm = 0; halt = 0; sample_en = 0; sample_pc = '0; sample_probe = '0;
    mode = '0; trig_pc = '0; post_trig = '0; rd_ready = 0;
    m_state = 0; m_ovf = 0; m_trig = 0; m_post_left = 0; m_mode = 0; m_tpc = '0; m_post_len = 0;

    applyStimulus(1, 0, 0, 0, '0, 0);
    check_val("reset_state", 64'(state), 64'(0));
    check_val("reset_count", 64'(count), 64'(0));

    // Ring mode: oldest two of ten samples are overwritten.
    arm_with(2'd0, '0, '0);
    for (int i = 1; i <= 10; i++) sample(PC_W'(i));
    applyStimulus(0, 0, 1, 0, '0, 0);
    check_val("ring_count", 64'(count), 64'(8));
    check_val("ring_ovf", 64'(overflow), 64'(1));
    check_val("ring_first_pc", 64'(rd_data[REC_W-1 -: PC_W]), 64'(3));
    drain();

    // Stop mode: freezes on the eighth write without overflow.
    arm_with(2'd1, '0, '0);
    for (int i = 1; i <= 12; i++) begin
      sample(PC_W'(i));
      if (i == 8) check_val("stop_frozen", 64'(state), 64'(3));
    end
    check_val("stop_ovf", 64'(overflow), 64'(0));
    check_val("stop_first_pc", 64'(rd_data[REC_W-1 -: PC_W]), 64'(1));
    drain();

    // Trigger mode with two post-trigger samples.
    arm_with(2'd2, 16'h0100, 3'd2);
    for (int pc = 16'h00F0; pc <= 16'h0110; pc += 4) begin
      sample(PC_W'(pc));
      if (pc == 16'h0104) check_val("trig_post", 64'(state), 64'(2));
      if (pc == 16'h0108) check_val("trig_frozen", 64'(state), 64'(3));
    end
    check_val("trig_flag", 64'(triggered), 64'(1));
    check_val("trig_count", 64'(count), 64'(7));
    drain();

    // Backpressure on a four-record readout.
    arm_with(2'd0, '0, '0);
    for (int i = 0; i < 4; i++) sample(PC_W'(16'h0200 + i));
    applyStimulus(0, 0, 1, 0, '0, 0);
    held = rd_data;
    repeat (3) begin
      idle(0);
      check_val("bp_hold", 64'(rd_data), 64'(held));
    end
    for (int i = 0; i < 8; i++) idle(i[0] == 1'b0);
    check_val("bp_empty", 64'(count), 64'(0));

    // Reset in the middle of the post-trigger phase, then a fresh capture.
    arm_with(2'd2, 16'h0100, 3'd3);
    sample(16'h00F0);
    sample(16'h0100);
    check_val("rst_in_post", 64'(state), 64'(2));
    applyStimulus(1, 0, 0, 0, '0, 0);
    check_val("rst_trig", 64'(triggered), 64'(0));
    arm_with(2'd0, '0, '0);
    for (int i = 0; i < 3; i++) sample(PC_W'(16'h0020 + i));
    applyStimulus(0, 0, 1, 0, '0, 0);
    check_val("rearm_first_pc", 64'(rd_data[REC_W-1 -: PC_W]), 64'(16'h0020));
    drain();

    // Zero post-trigger, halt on the trigger sample, arm coinciding with a sample.
    arm_with(2'd2, 16'h0040, 3'd0);
    sample(16'h003C);
    sample(16'h0040);
    check_val("post0_frozen", 64'(state), 64'(3));
    drain();
    arm_with(2'd2, 16'h0040, 3'd2);
    sample(16'h0010);
    applyStimulus(0, 0, 1, 1, 16'h0040, 0);
    check_val("halt_trig_state", 64'(state), 64'(3));
    check_val("halt_trig_count", 64'(count), 64'(2));
    drain();
    mode = 2'd0;
    applyStimulus(0, 1, 0, 1, 16'h0055, 0);
    check_val("arm_sample_count", 64'(count), 64'(0));
    applyStimulus(0, 0, 1, 0, '0, 0);

    // Random traffic, including reserved mode and mid-stream resets.
    for (int n = 0; n < 3000; n++) begin
      mode      = 2'($urandom_range(0, 3));
      trig_pc   = PC_W'($urandom_range(0, 15));
      post_trig = ADDR_W'($urandom_range(0, 7));
      applyStimulus($urandom_range(0, 199) == 0, $urandom_range(0, 29) == 0,
                    $urandom_range(0, 39) == 0, $urandom_range(0, 3) != 0,
                    PC_W'($urandom_range(0, 15)), $urandom_range(0, 1) == 1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
